// File: rtl/embed_onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Optional macro ARB_ADDR_CHECK_EN drops accesses at or above DEPTH and returns 32'hDEAD_BEEF on reads.
module embed_onchip_mem_arbiter #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DEPTH  = 4000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [3:0]        m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [31:0]       m0_writedata,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [3:0]        m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [31:0]       m1_writedata,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata
);

   if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
      $error("DEPTH does not fit in ADDR_W address bits");
   end

   logic              req0, req1;
   logic              gnt_vld, gnt_idx;
   logic              sel_wr, addr_oob;
   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        sel_be;
   logic [31:0]       sel_wdata;
   logic [31:0]       rd_data;

   logic last_grant_q, last_grant_d;
   logic rd_pend_q, rd_pend_d;
   logic rd_owner_q, rd_owner_d;
   logic rd_oob_q, rd_oob_d;

   always_comb begin
      req0    = m0_read | m0_write;
      req1    = m1_read | m1_write;
      gnt_vld = reset_n & (req0 | req1);
      // contention goes to the port that did not win last; otherwise whoever asks
      gnt_idx = (req0 & req1) ? ~last_grant_q : req1;

      sel_addr  = gnt_idx ? m1_address    : m0_address;
      sel_be    = gnt_idx ? m1_byteenable : m0_byteenable;
      sel_wdata = gnt_idx ? m1_writedata  : m0_writedata;
      sel_wr    = gnt_idx ? m1_write      : m0_write;

`ifdef ARB_ADDR_CHECK_EN
      addr_oob = (32'(sel_addr) >= DEPTH);
`else
      addr_oob = 1'b0;
`endif

      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      if (gnt_vld) begin
         mem_address    = sel_addr;
         mem_byteenable = sel_be;
         mem_writedata  = sel_wdata;
         mem_chipselect = ~addr_oob;
         mem_write      = sel_wr & ~addr_oob;
      end
      mem_clken = reset_n;

      m0_waitrequest = ~reset_n | (req0 & ~(gnt_vld & ~gnt_idx));
      m1_waitrequest = ~reset_n | (req1 & ~(gnt_vld & gnt_idx));

      last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
      rd_pend_d    = gnt_vld & ~sel_wr;
      rd_owner_d   = (gnt_vld & ~sel_wr) ? gnt_idx : rd_owner_q;
      rd_oob_d     = gnt_vld & ~sel_wr & addr_oob;

      rd_data          = rd_oob_q ? 32'hDEAD_BEEF : mem_readdata;
      m0_readdatavalid = rd_pend_q & ~rd_owner_q;
      m1_readdatavalid = rd_pend_q & rd_owner_q;
      m0_readdata      = m0_readdatavalid ? rd_data : '0;
      m1_readdata      = m1_readdatavalid ? rd_data : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
         rd_oob_q     <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
         rd_oob_q     <= rd_oob_d;
      end
   end

endmodule

// File: tb/tb_embed_onchip_mem_arbiter.sv
// Directed bench for embed_onchip_mem_arbiter with a behavioural single-port RAM behind it.
// Define ARB_ADDR_CHECK_EN for both bench and RTL to exercise the range-check build.
module tb_embed_onchip_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic [11:0] m0_address, m1_address, mem_address;
   logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, mem_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata, mem_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        mem_chipselect, mem_write, mem_clken;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] ram [4096] = '{default: '0};

   embed_onchip_mem_arbiter #(.ADDR_W(12), .DEPTH(4000)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // read-before-write RAM, data valid the cycle after the address edge
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         mem_readdata <= ram[mem_address];
         if (mem_write)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic g, p;
      reset_n = 1'b0;
      m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
      m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;

      // reset state, with a request present that must stay blocked
      repeat (2) @(negedge clk);
      m0_read = 1'b1;
      #2;
      check_val("rst_wait0",  m0_waitrequest,   1);
      check_val("rst_wait1",  m1_waitrequest,   1);
      check_val("rst_cs",     mem_chipselect,   0);
      check_val("rst_memwr",  mem_write,        0);
      check_val("rst_clken",  mem_clken,        0);
      check_val("rst_rdv0",   m0_readdatavalid, 0);
      check_val("rst_rdv1",   m1_readdatavalid, 0);
      check_val("rst_rdata0", m0_readdata,      0);

      // first write granted on the first edge after release
      @(negedge clk);
      reset_n = 1'b1; m0_read = 1'b0; m0_write = 1'b1;
      m0_address = 12'h005; m0_writedata = 32'h1122_3344; m0_byteenable = 4'hF;
      #2;
      check_val("wr_wait0", m0_waitrequest, 0);
      check_val("wr_memwr", mem_write,      1);
      check_val("wr_addr",  mem_address,    12'h005);
      check_val("wr_cs",    mem_chipselect, 1);
      check_val("wr_wdata", mem_writedata,  32'h1122_3344);
      check_val("wr_clken", mem_clken,      1);

      @(negedge clk);
      m0_write = 1'b0; m0_read = 1'b1;
      #2;
      check_val("rd_wait0", m0_waitrequest, 0);
      check_val("rd_memwr", mem_write,      0);
      check_val("rd_cs",    mem_chipselect, 1);
      check_val("wr_rdv0",  m0_readdatavalid, 0);

      @(negedge clk);
      m0_read = 1'b0;
      #2;
      check_val("rd_rdv0",    m0_readdatavalid, 1);
      check_val("rd_rdata0",  m0_readdata,      32'h1122_3344);
      check_val("rd_rdv1",    m1_readdatavalid, 0);
      check_val("rd_rdata1",  m1_readdata,      0);
      check_val("idle_wait0", m0_waitrequest,   0);
      check_val("idle_wait1", m1_waitrequest,   0);
      check_val("idle_cs",    mem_chipselect,   0);
      check_val("idle_addr",  mem_address,      0);

      // m1 alone; also preloads word 7 for the contention run
      @(negedge clk);
      m1_write = 1'b1; m1_address = 12'h007; m1_writedata = 32'hCAFE_0007; m1_byteenable = 4'hF;
      #2;
      check_val("m1wr_wait1", m1_waitrequest,   1'b0);
      check_val("m1wr_addr",  mem_address,      12'h007);
      check_val("post_rdv0",  m0_readdatavalid, 0);
      check_val("post_rdata0", m0_readdata,     0);

      // contention from a fresh reset: m0 first, then alternate
      @(negedge clk);
      m1_write = 1'b0; reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m0_read = 1'b1; m0_address = 12'h005;
      m1_read = 1'b1; m1_address = 12'h007;
      for (int k = 0; k < 6; k++) begin
         if (k != 0) @(negedge clk);
         #2;
         g = k[0];
         check_val($sformatf("rr%0d_wait0", k), m0_waitrequest, g);
         check_val($sformatf("rr%0d_wait1", k), m1_waitrequest, !g);
         check_val($sformatf("rr%0d_addr", k),  mem_address,    g ? 12'h007 : 12'h005);
         if (k == 0) begin
            check_val("rr0_rdv0", m0_readdatavalid, 0);
            check_val("rr0_rdv1", m1_readdatavalid, 0);
         end else begin
            p = !g;
            check_val($sformatf("rr%0d_rdv0", k),  m0_readdatavalid, !p);
            check_val($sformatf("rr%0d_rdv1", k),  m1_readdatavalid, p);
            check_val($sformatf("rr%0d_rdata", k), p ? m1_readdata : m0_readdata,
                      p ? 32'hCAFE_0007 : 32'h1122_3344);
         end
      end
      @(negedge clk);
      m0_read = 1'b0; m1_read = 1'b0;
      #2;
      check_val("rr6_rdv1",  m1_readdatavalid, 1);
      check_val("rr6_rdata", m1_readdata,      32'hCAFE_0007);
      check_val("rr6_rdv0",  m0_readdatavalid, 0);

      // partial byte-enable write then read back
      @(negedge clk);
      m1_write = 1'b1; m1_address = 12'h010; m1_writedata = 32'hAABB_CCDD; m1_byteenable = 4'h2;
      #2;
      check_val("be_wait1", m1_waitrequest, 0);
      check_val("be_be",    mem_byteenable, 4'h2);
      check_val("be_memwr", mem_write,      1);
      @(negedge clk);
      m1_write = 1'b0; m1_read = 1'b1;
      #2;
      check_val("be_rdwait1", m1_waitrequest, 0);
      @(negedge clk);
      m1_read = 1'b0;
      #2;
      check_val("be_rdv1",   m1_readdatavalid, 1);
      check_val("be_rdata1", m1_readdata,      32'h0000_CC00);

      // reset between a read grant and its data cycle
      @(negedge clk);
      m0_read = 1'b1; m0_address = 12'h005;
      #2;
      check_val("rrst_gnt0", m0_waitrequest, 0);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #2;
      check_val("rrst_rdv0",  m0_readdatavalid, 0);
      check_val("rrst_wait0", m0_waitrequest,   1);
      check_val("rrst_cs",    mem_chipselect,   0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1; m0_read = 1'b0;
      #2;
      check_val("rrst_post_rdv0a", m0_readdatavalid, 0);
      @(negedge clk);
      #2;
      check_val("rrst_post_rdv0b", m0_readdatavalid, 0);
      check_val("rrst_post_rdata", m0_readdata,      0);

      // address at/above DEPTH
      @(negedge clk);
      m1_write = 1'b1; m1_address = 12'hFA0; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
      #2;
      check_val("oob_wr_addr", mem_address, 12'hFA0);
`ifdef ARB_ADDR_CHECK_EN
      check_val("oob_wr_cs",    mem_chipselect, 0);
      check_val("oob_wr_memwr", mem_write,      0);
`else
      check_val("oob_wr_cs",    mem_chipselect, 1);
      check_val("oob_wr_memwr", mem_write,      1);
`endif
      check_val("oob_wr_wait1", m1_waitrequest, 0);
      @(negedge clk);
      m1_write = 1'b0; m1_read = 1'b1;
      #2;
`ifdef ARB_ADDR_CHECK_EN
      check_val("oob_rd_cs", mem_chipselect, 0);
`else
      check_val("oob_rd_cs", mem_chipselect, 1);
`endif
      @(negedge clk);
      m1_read = 1'b0;
      #2;
      check_val("oob_rdv1", m1_readdatavalid, 1);
`ifdef ARB_ADDR_CHECK_EN
      check_val("oob_rdata1", m1_readdata, 32'hDEAD_BEEF);
`else
      check_val("oob_rdata1", m1_readdata, 32'h1234_5678);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
